aes_128_iter_ctrl: RTL and testbench



---
 rtl/aes_128_iter_ctrl_pkg.sv | 96 +++++++++
 rtl/final_round_128.sv | 23 ++
 rtl/one_round_128.sv | 25 ++
 rtl/aes_128_iter_ctrl.sv | 131 +++++++++++++
 tb/tb_aes_128_iter_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/aes_128_iter_ctrl_pkg.sv
// Shared definitions for the iterative AES-128 sequencer and its round sub-blocks.
// Holds the controller FSM encoding, round constants, and the byte-level AES helpers
// (GF(2^8) arithmetic, S-box, ShiftRows, MixColumns, key expansion) used by both
// one_round_128 and final_round_128.
// Byte order everywhere: byte 0 sits in bits [127:120]; byte i is row i%4, column i/4.
package aes_128_iter_ctrl_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDone} ctrl_state_e;

   localparam logic [7:0]  RCON_INIT     = 8'h01;
   localparam logic [7:0]  RCON_POLY     = 8'h1b;
   localparam logic [3:0]  LAST_ROUND    = 4'd10;
   localparam int unsigned ROUND_LATENCY = 2;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Inverse computed as x^254 (0 maps to 0), then the FIPS-197 affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
      x2   = gf_mul(x, x);
      x3   = gf_mul(x2, x);
      x6   = gf_mul(x3, x3);
      x12  = gf_mul(x6, x6);
      x15  = gf_mul(x12, x3);
      x30  = gf_mul(x15, x15);
      x60  = gf_mul(x30, x30);
      x120 = gf_mul(x60, x60);
      x240 = gf_mul(x120, x120);
      inv  = gf_mul(gf_mul(x240, x12), x2);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      return {sub_word(s[127:96]), sub_word(s[95:64]), sub_word(s[63:32]), sub_word(s[31:0])};
   endfunction

   // Row r rotates left by r columns.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      return {mix_column(s[127:96]), mix_column(s[95:64]),
              mix_column(s[63:32]), mix_column(s[31:0])};
   endfunction

   // One step of the AES-128 key schedule: produces the next 4-word round key.
   function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rcon);
      logic [31:0] w0, w1, w2, w3, t;
      t  = sub_word({k[23:0], k[31:24]}) ^ {rcon, 24'h000000};
      w0 = k[127:96] ^ t;
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/final_round_128.sv
// AES-128 last round: SubBytes, ShiftRows, AddRoundKey with the final expanded key
// (no MixColumns). Same two-cycle latency as one_round_128; registers are not reset.
// Ports: clk; state_in/key_in/rcon round inputs; state_out ciphertext.
module final_round_128
   import aes_128_iter_ctrl_pkg::*;
(
   input  logic         clk,
   input  logic [127:0] state_in,
   input  logic [127:0] key_in,
   input  logic [7:0]   rcon,
   output logic [127:0] state_out
);

   logic [127:0] sub_q;
   logic [127:0] rkey_q;

   always_ff @(posedge clk) begin
      sub_q     <= sub_bytes(state_in);
      rkey_q    <= expand_key(key_in, rcon);
      state_out <= shift_rows(sub_q) ^ rkey_q;
   end

endmodule

// File: rtl/one_round_128.sv
// One full AES-128 round (SubBytes, ShiftRows, MixColumns, AddRoundKey) with the matching
// key-schedule step. Two-cycle, non-stalling latency; registers are not reset.
// Ports: clk; state_in/key_in/rcon round inputs; state_out/key_out round results.
module one_round_128
   import aes_128_iter_ctrl_pkg::*;
(
   input  logic         clk,
   input  logic [127:0] state_in,
   input  logic [127:0] key_in,
   input  logic [7:0]   rcon,
   output logic [127:0] state_out,
   output logic [127:0] key_out
);

   logic [127:0] sub_q;
   logic [127:0] rkey_q;

   always_ff @(posedge clk) begin
      sub_q     <= sub_bytes(state_in);
      rkey_q    <= expand_key(key_in, rcon);
      state_out <= mix_columns(shift_rows(sub_q)) ^ rkey_q;
      key_out   <= rkey_q;
   end

endmodule

// File: rtl/aes_128_iter_ctrl.sv
// Iterative AES-128 encryption sequencer. Accepts plaintext/key, applies the initial
// AddRoundKey, then iterates one_round_128 for rounds 1..9 and final_round_128 for round 10,
// spending 3 cycles per round. Ciphertext is offered on a valid/ready handshake.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input handshake (in_ready high only in idle)
//   plaintext, key           128-bit inputs, byte 0 in [127:120]
//   out_valid/out_ready      output handshake (out_valid registered)
//   ciphertext               128-bit result, held after the handshake
module aes_128_iter_ctrl
   import aes_128_iter_ctrl_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ciphertext
);

   ctrl_state_e  fsm_q, fsm_d;
   logic [127:0] state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [7:0]   rcon_q, rcon_d;
   logic [3:0]   round_q, round_d;
   logic [1:0]   phase_q, phase_d;
   logic [127:0] ct_q, ct_d;
   logic         out_valid_q, out_valid_d;

   logic [127:0] rnd_state;
   logic [127:0] rnd_key;
   logic [127:0] fin_state;

   // Both sub-blocks see the same held inputs; only the one matching round_q is captured.
   one_round_128 u_one_round (
      .clk      (clk),
      .state_in (state_q),
      .key_in   (key_q),
      .rcon     (rcon_q),
      .state_out(rnd_state),
      .key_out  (rnd_key)
   );

   final_round_128 u_final_round (
      .clk      (clk),
      .state_in (state_q),
      .key_in   (key_q),
      .rcon     (rcon_q),
      .state_out(fin_state)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q       <= StIdle;
         state_q     <= '0;
         key_q       <= '0;
         rcon_q      <= '0;
         round_q     <= '0;
         phase_q     <= '0;
         ct_q        <= '0;
         out_valid_q <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         state_q     <= state_d;
         key_q       <= key_d;
         rcon_q      <= rcon_d;
         round_q     <= round_d;
         phase_q     <= phase_d;
         ct_q        <= ct_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      fsm_d       = fsm_q;
      state_d     = state_q;
      key_d       = key_q;
      rcon_d      = rcon_q;
      round_d     = round_q;
      phase_d     = phase_q;
      ct_d        = ct_q;
      out_valid_d = out_valid_q;

      case (fsm_q)
         StIdle: begin
            if (in_valid) begin
               state_d = plaintext ^ key;
               key_d   = key;
               rcon_d  = RCON_INIT;
               round_d = 4'd1;
               phase_d = 2'd0;
               fsm_d   = StRun;
            end
         end
         StRun: begin
            // Sub-block output is valid once ROUND_LATENCY edges have passed on stable inputs.
            if (phase_q == ROUND_LATENCY[1:0]) begin
               phase_d = 2'd0;
               rcon_d  = xtime(rcon_q);
               round_d = round_q + 4'd1;
               if (round_q == LAST_ROUND) begin
                  state_d     = fin_state;
                  ct_d        = fin_state;
                  out_valid_d = 1'b1;
                  fsm_d       = StDone;
               end else begin
                  state_d = rnd_state;
                  key_d   = rnd_key;
               end
            end else begin
               phase_d = phase_q + 2'd1;
            end
         end
         StDone: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               fsm_d       = StIdle;
            end
         end
         default: fsm_d = StIdle;
      endcase
   end

   assign in_ready   = (fsm_q == StIdle);
   assign out_valid  = out_valid_q;
   assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes_128_iter_ctrl.sv
// Directed self-checking bench for aes_128_iter_ctrl using FIPS-197 vectors.
module tb_aes_128_iter_ctrl;

   localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] R1_S = 128'ha49c7ff2689f352b6b5bea43026a5049;
   localparam logic [127:0] R1_K = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K_C  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] plaintext;
   logic [127:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] ciphertext;

   int tests_run;
   int tests_failed;
   int cyc;
   int accept_cyc;

   aes_128_iter_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .plaintext (plaintext),
      .key       (key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ciphertext(ciphertext)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offers pt/k and returns just after the accepting edge.
   task automatic accept(input logic [127:0] pt, input logic [127:0] k);
      int n;
      plaintext = pt;
      key       = k;
      in_valid  = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      if (!in_ready) check_eq("accept_timeout", 128'd0, 128'd1);
      step();
      accept_cyc = cyc;
      in_valid   = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
         step();
         n++;
      end
      lat = cyc - accept_cyc;
   endtask

   initial begin
      int           lat;
      int           acc_n;
      int           out_n;
      int           acc_cyc [4];
      logic [127:0] outs [4];
      logic         pre_acc;
      logic         pre_out;
      logic [127:0] pre_ct;
      logic [7:0]   rcon_tbl [10];

      rcon_tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
      tests_run    = 0;
      tests_failed = 0;
      accept_cyc   = 0;
      rst          = 1'b1;
      in_valid     = 1'b0;
      out_ready    = 1'b1;
      plaintext    = '0;
      key          = '0;
      repeat (2) step();
      rst = 1'b0;

      // Reset state
      check_eq("rst_in_ready", 128'(in_ready), 128'd1);
      check_eq("rst_out_valid", 128'(out_valid), 128'd0);
      check_eq("rst_ciphertext", ciphertext, 128'd0);
      check_eq("rst_state_q", dut.state_q, 128'd0);
      check_eq("rst_rcon_q", 128'(dut.rcon_q), 128'd0);

      // App. B with round-1 probe and latency
      accept(PT_B, K_B);
      check_eq("b_in_ready_busy", 128'(in_ready), 128'd0);
      repeat (3) step();
      check_eq("b_r1_state", dut.state_q, R1_S);
      check_eq("b_r1_key", dut.key_q, R1_K);
      wait_out(lat);
      check_eq("b_latency", 128'(lat), 128'd30);
      check_eq("b_ciphertext", ciphertext, CT_B);
      step();
      check_eq("b_out_valid_drop", 128'(out_valid), 128'd0);
      check_eq("b_in_ready_back", 128'(in_ready), 128'd1);
      check_eq("b_ct_kept", ciphertext, CT_B);

      // App. C.1 with rcon probe and backpressure
      out_ready = 1'b0;
      accept(PT_C, K_C);
      for (int r = 0; r < 10; r++) begin
         check_eq($sformatf("rcon_r%0d", r + 1), 128'(dut.rcon_q), 128'(rcon_tbl[r]));
         if (r < 9) repeat (3) step();
      end
      wait_out(lat);
      check_eq("c_latency", 128'(lat), 128'd30);
      check_eq("c_ciphertext", ciphertext, CT_C);
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            in_valid  = 1'b1;
            plaintext = PT_B;
            key       = K_B;
         end else begin
            in_valid = 1'b0;
         end
         step();
         check_eq($sformatf("bp_ct_%0d", i), ciphertext, CT_C);
         check_eq($sformatf("bp_ov_%0d", i), 128'(out_valid), 128'd1);
         check_eq($sformatf("bp_ir_%0d", i), 128'(in_ready), 128'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      check_eq("bp_release_ov", 128'(out_valid), 128'd0);
      check_eq("bp_release_ir", 128'(in_ready), 128'd1);
      check_eq("bp_release_ct", ciphertext, CT_C);

      // Back-to-back: B then C, in_valid held, out_ready high
      acc_n     = 0;
      out_n     = 0;
      plaintext = PT_B;
      key       = K_B;
      in_valid  = 1'b1;
      for (int i = 0; i < 70; i++) begin
         pre_acc = in_ready && in_valid;
         pre_out = out_valid && out_ready;
         pre_ct  = ciphertext;
         step();
         if (pre_acc && acc_n < 4) begin
            acc_cyc[acc_n] = cyc;
            acc_n++;
            if (acc_n == 1) begin
               plaintext = PT_C;
               key       = K_C;
            end else begin
               in_valid = 1'b0;
            end
         end
         if (pre_out && out_n < 4) begin
            outs[out_n] = pre_ct;
            out_n++;
         end
      end
      in_valid = 1'b0;
      check_eq("b2b_accepts", 128'(acc_n), 128'd2);
      check_eq("b2b_outputs", 128'(out_n), 128'd2);
      if (acc_n >= 2) check_eq("b2b_interval", 128'(acc_cyc[1] - acc_cyc[0]), 128'd32);
      if (out_n >= 2) begin
         check_eq("b2b_ct0", outs[0], CT_B);
         check_eq("b2b_ct1", outs[1], CT_C);
      end

      // Reset mid-operation at round 5
      accept(PT_C, K_C);
      repeat (12) step();
      check_eq("mid_round", 128'(dut.round_q), 128'd5);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("mid_rst_in_ready", 128'(in_ready), 128'd1);
      check_eq("mid_rst_out_valid", 128'(out_valid), 128'd0);
      check_eq("mid_rst_ct", ciphertext, 128'd0);
      check_eq("mid_rst_round", 128'(dut.round_q), 128'd0);
      accept(PT_B, K_B);
      wait_out(lat);
      check_eq("post_rst_latency", 128'(lat), 128'd30);
      check_eq("post_rst_ct", ciphertext, CT_B);
      step();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
